queue_dispatcher: RTL and testbench
===================================

Name: queue_dispatcher

Overview:
- Front-end scheduler for the bank-queue system.
- Accepts arriving customers, issues ticket numbers and buffers them in a FIFO.
- Dispatches each customer to a free service counter by pulsing that counter's load strobe with ticket number and service time.
- Shares a pool of NUM_CTR counters round-robin; one dispatch per cycle maximum.

Parameters:
- NUM_CTR, 2, number of service counters driven (1..8).
- DEPTH, 8, FIFO entries (power of 2, ≥2).
- NW, 4, ticket-number width.
- TW, 4, service-time width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-high.
- arr  input  1  customer arrival strobe, one cycle per customer.
- arr_tim  input  TW  service time of arriving customer, in clock cycles.
- tkt  output  NW  ticket assigned to the last accepted arrival.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- qcnt  output  clog2(DEPTH)+1  entries waiting.
- drop  output  1  one-cycle pulse: arrival rejected.
- ctr_busy  input  NUM_CTR  busy flags from counters.
- ld  output  NUM_CTR  one-hot load strobe to counters.
- dn  output  NW  ticket to loaded counter.
- dt  output  TW  service time to loaded counter.

Behaviour:
- Reset (rst_n=1, async): ld=0, dn=0, dt=0, tkt=0, qcnt=0, empty=1, full=0, drop=0, pending mask=0, rr pointer=0, next ticket=1.
- Arrival, sampled at edge E:
  - arr=1 and arr_tim≠0 and !full (registered value before E): push {ticket, arr_tim}; tkt<=ticket; next ticket increments.
  - Ticket sequence is 1..2^NW−1, then wraps to 1; 0 is never issued.
  - arr=1 with full=1 or arr_tim=0: no push, ticket not consumed, drop=1 for one cycle.
- Counter free iff ctr_busy[k]=0 and pending[k]=0.
- Dispatch at edge E when qcnt>0 (registered) and at least one counter is free:
  - Choose the first free counter searching from rr upward, wrapping.
  - Pop FIFO head. ld[k]<=1, dn<=head ticket, dt<=head time. rr<=(k+1) mod NUM_CTR. pending[k]<=1.
- Outputs are registered. ld is a one-cycle pulse; dn/dt are valid only while ld≠0, otherwise 0.
- pending[k] clears at the first edge where ctr_busy[k]=1 is sampled after ld[k]. This prevents double-loading during the counter's load-to-busy latency.
- Minimum latency: arrival at E0 → ld high during cycle E1–E2 (qcnt=1 after E0).
- Simultaneous push and pop at the same edge: qcnt unchanged.
  - Push with full=1 is dropped even if a pop happens at the same edge.
  - Pop from empty never occurs; a push into an empty FIFO is not dispatched in the same cycle.
- FIFO order strictly preserved; pointers wrap mod DEPTH.
- Reset mid-operation: queued customers discarded, any ld pulse aborted immediately, ticket sequence restarts at 1.

Optional Feature:
- Macro: QD_SERVED_CNT_EN.
- Defined:
  - Adds output served (8 bits), reset 0.
  - Increments on each dispatch; saturates at 255.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset then arr with arr_tim=3 at one edge, counters idle → tkt=1 next cycle; ld=2'b01, dn=1, dt=3 exactly one cycle, two cycles after arrival; qcnt returns to 0.
- Three arrivals (times 5,5,5) on consecutive cycles, NUM_CTR=2 → tickets 1,2 to counters 0,1 (round-robin); ticket 3 waits with qcnt=1 until counter 0 busy falls, then ld=2'b01, dn=3.
- Hold ctr_busy=2'b11, issue 9 arrivals with DEPTH=8 → full=1 after 8th; 9th gives drop=1; tkt stays 8; next accepted arrival after a pop gets ticket 9.
- Arrival with arr_tim=0 → drop=1, qcnt unchanged, next valid arrival receives the unconsumed ticket number.
- Issue 17 accepted arrivals (NW=4), draining as they go → tickets run 1..15, then 1, 2; never 0.
- Assert rst_n=1 mid-stream with qcnt=4 and ld active → ld, dn, dt, qcnt drop to 0 asynchronously; first arrival after release gets tkt=1.

Source files
------------

// File: rtl/queue_dispatcher.sv
// queue_dispatcher: front-end scheduler for the bank-queue system.
// Issues ticket numbers to arriving customers, buffers them in a FIFO and
// loads free service counters round-robin, at most one dispatch per cycle.
// Optional build macro QD_SERVED_CNT_EN adds an 8-bit saturating 'served'
// output that counts dispatches.
module queue_dispatcher #(
  parameter int NUM_CTR = 2,
  parameter int DEPTH   = 8,
  parameter int NW      = 4,
  parameter int TW      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arr,
  input  logic [TW-1:0]              arr_tim,
  output logic [NW-1:0]              tkt,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     qcnt,
  output logic                       drop,
  input  logic [NUM_CTR-1:0]         ctr_busy,
  output logic [NUM_CTR-1:0]         ld,
  output logic [NW-1:0]              dn,
  output logic [TW-1:0]              dt
`ifdef QD_SERVED_CNT_EN
  ,
  output logic [7:0]                 served
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = AW + 1;
  localparam int CW = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1;

  // FIFO storage: {ticket, service time}
  logic [NW+TW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [QW-1:0]      cnt_q, cnt_d;

  logic [NW-1:0]      tkt_q, tkt_d;
  logic [NW-1:0]      nxt_q, nxt_d;
  logic               drop_q, drop_d;
  logic [NUM_CTR-1:0] ld_q, ld_d;
  logic [NW-1:0]      dn_q, dn_d;
  logic [TW-1:0]      dt_q, dt_d;
  logic [NUM_CTR-1:0] pend_q, pend_d;
  logic [CW-1:0]      rr_q, rr_d;

  logic [NUM_CTR-1:0] free;
  logic [CW-1:0]      sel;
  logic               found;
  logic               push;
  logic               pop;
  logic [NW+TW-1:0]   head;

  assign full  = (cnt_q == QW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign qcnt  = cnt_q;
  assign tkt   = tkt_q;
  assign drop  = drop_q;
  assign ld    = ld_q;
  assign dn    = dn_q;
  assign dt    = dt_q;

  // Zero service time and arrivals into a full FIFO are rejected; the
  // full flag is the registered one, so a same-edge pop does not help.
  assign push = arr && (arr_tim != '0) && !full;
  // Pop only from a FIFO that was non-empty before the edge, so a fresh
  // arrival is never dispatched in the cycle it is pushed.
  assign pop  = !empty && found;
  assign head = mem_q[rd_ptr_q];

  // A counter is free when idle and not awaiting its busy flag after a load;
  // pending holds until busy is first seen, covering the load-to-busy latency.
  generate
    for (genvar gi = 0; gi < NUM_CTR; gi++) begin : g_ctr
      assign free[gi]   = !ctr_busy[gi] && !pend_q[gi];
      assign pend_d[gi] = (pend_q[gi] && !ctr_busy[gi]) || (pop && (sel == CW'(gi)));
    end
  endgenerate

  // Round-robin search for the first free counter starting at rr_q.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_CTR; i++) begin
      idx = (int'(rr_q) + i) % NUM_CTR;
      if (!found && free[idx]) begin
        found = 1'b1;
        sel   = CW'(idx);
      end
    end
  end

  // Next-state for FIFO pointers, ticket issue and dispatch outputs.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tkt_d    = tkt_q;
    nxt_d    = nxt_q;
    rr_d     = rr_q;
    ld_d     = '0;
    dn_d     = '0;
    dt_d     = '0;
    drop_d   = arr && !push;
    cnt_d    = cnt_q + QW'(push) - QW'(pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      tkt_d    = nxt_q;
      // Ticket 0 is reserved: wrap from all-ones back to 1.
      nxt_d    = (nxt_q == {NW{1'b1}}) ? NW'(1) : nxt_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      ld_d[sel]   = 1'b1;
      {dn_d, dt_d} = head;
      rr_d        = (sel == CW'(NUM_CTR - 1)) ? '0 : sel + 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tkt_q    <= '0;
      nxt_q    <= NW'(1);
      drop_q   <= 1'b0;
      ld_q     <= '0;
      dn_q     <= '0;
      dt_q     <= '0;
      pend_q   <= '0;
      rr_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      tkt_q    <= tkt_d;
      nxt_q    <= nxt_d;
      drop_q   <= drop_d;
      ld_q     <= ld_d;
      dn_q     <= dn_d;
      dt_q     <= dt_d;
      pend_q   <= pend_d;
      rr_q     <= rr_d;
    end
  end

  // FIFO storage write; kept reset-free so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {nxt_q, arr_tim};
    end
  end

`ifdef QD_SERVED_CNT_EN
  logic [7:0] served_q;
  assign served = served_q;

  // Saturating count of dispatches.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      served_q <= '0;
    end else if (pop && (served_q != 8'hFF)) begin
      served_q <= served_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_queue_dispatcher.sv
// Self-checking bench for queue_dispatcher (NUM_CTR=2, DEPTH=8, NW=4, TW=4).
// A queue-based reference model predicts every registered output per cycle;
// an optional counter emulator turns load strobes into busy flags.
module tb_queue_dispatcher;

  localparam int N = 2;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       arr = 1'b0;
  logic [3:0] arr_tim = '0;
  logic [3:0] tkt;
  logic       full, empty, drop;
  logic [3:0] qcnt;
  logic [1:0] ctr_busy = '0;
  logic [1:0] ld;
  logic [3:0] dn, dt;
`ifdef QD_SERVED_CNT_EN
  logic [7:0] served;
`endif

  queue_dispatcher #(.NUM_CTR(N), .DEPTH(D), .NW(4), .TW(4)) dut (
    .clk(clk), .rst_n(rst_n), .arr(arr), .arr_tim(arr_tim), .tkt(tkt),
    .full(full), .empty(empty), .qcnt(qcnt), .drop(drop),
    .ctr_busy(ctr_busy), .ld(ld), .dn(dn), .dt(dt)
`ifdef QD_SERVED_CNT_EN
    , .served(served)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] mq[$];
  int         m_nxt;
  logic [1:0] m_pend;
  int         m_rr;
  logic [3:0] e_tkt;
  logic       e_drop;
  logic [1:0] e_ld;
  logic [3:0] e_dn, e_dt;
  // Counter emulator: remaining busy cycles per counter
  int         rem[N];
  bit         emu_on = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_nxt = 1; m_pend = '0; m_rr = 0;
    e_tkt = '0; e_drop = 1'b0; e_ld = '0; e_dn = '0; e_dt = '0;
    for (int k = 0; k < N; k++) rem[k] = 0;
  endtask

  function automatic logic [20:0] exp_v();
    int c;
    c = mq.size();
    return {e_tkt, (c == D), (c == 0), 4'(c), e_drop, e_ld, e_dn, e_dt};
  endfunction

  function automatic logic [20:0] dut_v();
    return {tkt, full, empty, qcnt, drop, ld, dn, dt};
  endfunction

  // Drive one cycle of stimulus, advance the model at the edge, return at edge+1.
  task automatic tick(input logic a, input logic [3:0] t, input logic [1:0] bman);
    logic [1:0] b;
    logic [1:0] np;
    int         cnt, sel, k;
    bit         pop, push;
    if (emu_on) begin
      for (int i = 0; i < N; i++) b[i] = (rem[i] != 0);
    end else begin
      b = bman;
    end
    arr = a; arr_tim = t; ctr_busy = b;
    @(posedge clk);
    cnt = mq.size();
    sel = -1;
    if (cnt > 0) begin
      for (int i = 0; i < N; i++) begin
        k = (m_rr + i) % N;
        if (sel < 0 && !b[k] && !m_pend[k]) sel = k;
      end
    end
    pop = (sel >= 0);
    for (int i = 0; i < N; i++) np[i] = (m_pend[i] && !b[i]) || (pop && i == sel);
    m_pend = np;
    for (int i = 0; i < N; i++) begin
      if (e_ld[i]) rem[i] = int'(e_dt);
      else if (rem[i] > 0) rem[i]--;
    end
    e_ld = '0; e_dn = '0; e_dt = '0;
    if (pop) begin
      {e_dn, e_dt} = mq.pop_front();
      e_ld[sel] = 1'b1;
      m_rr = (sel + 1) % N;
    end
    push = a && (t != 0) && (cnt != D);
    if (push) begin
      mq.push_back({4'(m_nxt), t});
      e_tkt = 4'(m_nxt);
      m_nxt = (m_nxt == 15) ? 1 : m_nxt + 1;
    end
    e_drop = a && !push;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b1;
    arr = 1'b0; arr_tim = '0; ctr_busy = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] want;
    apply_reset();
    want = {4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 2'b00, 4'd0, 4'd0};
    n_cmp++;
    if (dut_v() !== want) begin
      n_err++; $display("FAIL reset_state: got %h expected %h", dut_v(), want);
    end
    $display("reset: outputs %h", dut_v());
  endtask

  task automatic test_single();
    apply_reset();
    emu_on = 1'b0;
    tick(1'b1, 4'd3, 2'b00);
    n_cmp++;
    if (tkt !== 4'd1 || qcnt !== 4'd1) begin
      n_err++; $display("FAIL single_push: tkt %0d qcnt %0d expected 1 1", tkt, qcnt);
    end
    tick(1'b0, 4'd0, 2'b00);
    n_cmp++;
    if (ld !== 2'b01 || dn !== 4'd1 || dt !== 4'd3 || qcnt !== 4'd0) begin
      n_err++; $display("FAIL single_load: ld %b dn %0d dt %0d qcnt %0d expected 01 1 3 0", ld, dn, dt, qcnt);
    end
    tick(1'b0, 4'd0, 2'b00);
    n_cmp++;
    if (ld !== 2'b00 || dn !== 4'd0 || dt !== 4'd0) begin
      n_err++; $display("FAIL single_pulse: ld %b dn %0d dt %0d expected 00 0 0", ld, dn, dt);
    end
    $display("single: ticket 1 dispatched to counter 0");
  endtask

  task automatic test_round_robin();
    bit got;
    apply_reset();
    emu_on = 1'b1;
    tick(1'b1, 4'd5, 2'b00);
    tick(1'b1, 4'd5, 2'b00);
    n_cmp++;
    if (ld !== 2'b01 || dn !== 4'd1) begin
      n_err++; $display("FAIL rr_first: ld %b dn %0d expected 01 1", ld, dn);
    end
    tick(1'b1, 4'd5, 2'b00);
    n_cmp++;
    if (ld !== 2'b10 || dn !== 4'd2) begin
      n_err++; $display("FAIL rr_second: ld %b dn %0d expected 10 2", ld, dn);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1'b0, 4'd0, 2'b00);
      n_cmp++;
      if (dut_v() !== exp_v()) begin
        n_err++; $display("FAIL rr_model: got %h expected %h", dut_v(), exp_v());
      end
      if (ld != 2'b00) begin
        got = 1'b1;
      end else begin
        n_cmp++;
        if (qcnt !== 4'd1) begin
          n_err++; $display("FAIL rr_wait_qcnt: got %0d expected 1", qcnt);
        end
      end
    end
    n_cmp++;
    if (!got || ld !== 2'b01 || dn !== 4'd3) begin
      n_err++; $display("FAIL rr_third: seen %0d ld %b dn %0d expected 1 01 3", got, ld, dn);
    end
    $display("round_robin: tickets 1,2,3 -> counters 0,1,0");
    emu_on = 1'b0;
  endtask

  task automatic test_full_drop();
    apply_reset();
    emu_on = 1'b0;
    for (int i = 0; i < 8; i++) tick(1'b1, 4'd2, 2'b11);
    n_cmp++;
    if (full !== 1'b1 || tkt !== 4'd8 || qcnt !== 4'd8) begin
      n_err++; $display("FAIL full_set: full %b tkt %0d qcnt %0d expected 1 8 8", full, tkt, qcnt);
    end
    tick(1'b1, 4'd2, 2'b11);
    n_cmp++;
    if (drop !== 1'b1 || tkt !== 4'd8 || qcnt !== 4'd8) begin
      n_err++; $display("FAIL full_drop: drop %b tkt %0d qcnt %0d expected 1 8 8", drop, tkt, qcnt);
    end
    // Arrival while full is dropped even though a pop happens at the same edge.
    tick(1'b1, 4'd2, 2'b00);
    n_cmp++;
    if (drop !== 1'b1 || qcnt !== 4'd7 || ld !== 2'b01 || dn !== 4'd1) begin
      n_err++; $display("FAIL full_pop_drop: drop %b qcnt %0d ld %b dn %0d expected 1 7 01 1", drop, qcnt, ld, dn);
    end
    tick(1'b1, 4'd4, 2'b11);
    n_cmp++;
    if (tkt !== 4'd9 || drop !== 1'b0 || full !== 1'b1) begin
      n_err++; $display("FAIL full_next_tkt: tkt %0d drop %b full %b expected 9 0 1", tkt, drop, full);
    end
    $display("full_drop: drop seen, next ticket %0d", tkt);
  endtask

  task automatic test_zero_time();
    apply_reset();
    tick(1'b1, 4'd3, 2'b11);
    tick(1'b1, 4'd0, 2'b11);
    n_cmp++;
    if (drop !== 1'b1 || qcnt !== 4'd1 || tkt !== 4'd1) begin
      n_err++; $display("FAIL zero_drop: drop %b qcnt %0d tkt %0d expected 1 1 1", drop, qcnt, tkt);
    end
    tick(1'b1, 4'd6, 2'b11);
    n_cmp++;
    if (tkt !== 4'd2 || qcnt !== 4'd2 || drop !== 1'b0) begin
      n_err++; $display("FAIL zero_next: tkt %0d qcnt %0d drop %b expected 2 2 0", tkt, qcnt, drop);
    end
    $display("zero_time: rejected, ticket 2 reused");
  endtask

  task automatic test_wrap();
    logic [3:0] want;
    apply_reset();
    emu_on = 1'b1;
    for (int n = 0; n < 17; n++) begin
      tick(1'b1, 4'd1, 2'b00);
      want = 4'((n % 15) + 1);
      n_cmp++;
      if (tkt !== want || tkt === 4'd0 || drop !== 1'b0) begin
        n_err++; $display("FAIL wrap_tkt: arrival %0d tkt %0d drop %b expected %0d 0", n, tkt, drop, want);
      end
      repeat (3) begin
        tick(1'b0, 4'd0, 2'b00);
        n_cmp++;
        if (dut_v() !== exp_v()) begin
          n_err++; $display("FAIL wrap_model: got %h expected %h", dut_v(), exp_v());
        end
      end
    end
    $display("wrap: 17 tickets issued, last %0d", tkt);
    emu_on = 1'b0;
  endtask

  task automatic test_random();
    logic       a;
    logic [3:0] t;
    logic [1:0] b;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      emu_on = (i >= 300);
      a = ($urandom_range(0, 99) < 60);
      t = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      b = 2'($urandom_range(0, 3));
      tick(a, t, b);
      n_cmp++;
      if (dut_v() !== exp_v()) begin
        n_err++; $display("FAIL random_cycle %0d: got %h expected %h", i, dut_v(), exp_v());
      end
    end
    $display("random: 600 cycles against model");
    emu_on = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 4'd2, 2'b11);
    tick(1'b0, 4'd0, 2'b00);
    n_cmp++;
    if (ld !== 2'b01 || qcnt !== 4'd4) begin
      n_err++; $display("FAIL mid_setup: ld %b qcnt %0d expected 01 4", ld, qcnt);
    end
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ld !== 2'b00 || dn !== 4'd0 || dt !== 4'd0 || qcnt !== 4'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL mid_async: ld %b dn %0d dt %0d qcnt %0d empty %b expected 00 0 0 0 1", ld, dn, dt, qcnt, empty);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick(1'b1, 4'd3, 2'b00);
    n_cmp++;
    if (tkt !== 4'd1 || qcnt !== 4'd1) begin
      n_err++; $display("FAIL mid_restart: tkt %0d qcnt %0d expected 1 1", tkt, qcnt);
    end
    $display("reset_mid: aborted and restarted at ticket %0d", tkt);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_full_drop();
    test_zero_time();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
